// File: rtl/id_ex_ctrl_reg.sv
// ID/EX control-word pipeline register with stall, flush and
// a fence drain sequencer that holds the front end after a fence.
module id_ex_ctrl_reg #(
  parameter int ALU_CTRL_W   = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_flush_EX,
  input  logic                  i_jump_ID,
  input  logic                  i_branch_ID,
  input  logic                  i_reg_write_ID,
  input  logic [1:0]            i_result_src_ID,
  input  logic                  i_mem_write_ID,
  input  logic [ALU_CTRL_W-1:0] i_alu_ctrl_ID,
  input  logic                  i_alu_src_ID,
  input  logic                  i_addr_src_ID,
  input  logic                  i_fence_ID,
  output logic                  o_jump_EX,
  output logic                  o_branch_EX,
  output logic                  o_reg_write_EX,
  output logic [1:0]            o_result_src_EX,
  output logic                  o_mem_write_EX,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl_EX,
  output logic                  o_alu_src_EX,
  output logic                  o_addr_src_EX,
  output logic                  o_fence_EX,
  output logic                  o_fence_stall
);

  typedef struct packed {
    logic                  jump;
    logic                  branch;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  addr_src;
    logic                  fence;
  } ctrl_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_t            id_word;
  ctrl_t            ex_q, ex_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;

  assign id_word = '{
    jump:       i_jump_ID,
    branch:     i_branch_ID,
    reg_write:  i_reg_write_ID,
    result_src: i_result_src_ID,
    mem_write:  i_mem_write_ID,
    alu_ctrl:   i_alu_ctrl_ID,
    alu_src:    i_alu_src_ID,
    addr_src:   i_addr_src_ID,
    fence:      i_fence_ID
  };

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    unique case (state_q)
      IDLE: begin
        if (i_flush_EX) begin
          ex_d = '0;
        end else if (i_en) begin
          ex_d = id_word;
          if (i_fence_ID) begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
            stall_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Bubbles only while older instructions retire.
        ex_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          stall_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_jump_EX       = ex_q.jump;
  assign o_branch_EX     = ex_q.branch;
  assign o_reg_write_EX  = ex_q.reg_write;
  assign o_result_src_EX = ex_q.result_src;
  assign o_mem_write_EX  = ex_q.mem_write;
  assign o_alu_ctrl_EX   = ex_q.alu_ctrl;
  assign o_alu_src_EX    = ex_q.alu_src;
  assign o_addr_src_EX   = ex_q.addr_src;
  assign o_fence_EX      = ex_q.fence;
  assign o_fence_stall   = stall_q;

endmodule

// File: tb/tb_id_ex_ctrl_reg.sv
// Randomized bench for id_ex_ctrl_reg against a
// drain-count reference model of the control register.
module tb_id_ex_ctrl_reg;

  localparam int W  = 5;
  localparam int DC = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, flush;
  logic         jump, branch, reg_write, mem_write;
  logic [1:0]   result_src;
  logic [W-1:0] alu_ctrl;
  logic         alu_src, addr_src, fence;
  logic         jump_ex, branch_ex, reg_write_ex, mem_write_ex;
  logic [1:0]   result_src_ex;
  logic [W-1:0] alu_ctrl_ex;
  logic         alu_src_ex, addr_src_ex, fence_ex, fence_stall;

  always #5 clk = ~clk;

  id_ex_ctrl_reg #(
    .ALU_CTRL_W  (W),
    .DRAIN_CYCLES(DC),
    .CNT_W       (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_flush_EX     (flush),
    .i_jump_ID      (jump),
    .i_branch_ID    (branch),
    .i_reg_write_ID (reg_write),
    .i_result_src_ID(result_src),
    .i_mem_write_ID (mem_write),
    .i_alu_ctrl_ID  (alu_ctrl),
    .i_alu_src_ID   (alu_src),
    .i_addr_src_ID  (addr_src),
    .i_fence_ID     (fence),
    .o_jump_EX      (jump_ex),
    .o_branch_EX    (branch_ex),
    .o_reg_write_EX (reg_write_ex),
    .o_result_src_EX(result_src_ex),
    .o_mem_write_EX (mem_write_ex),
    .o_alu_ctrl_EX  (alu_ctrl_ex),
    .o_alu_src_EX   (alu_src_ex),
    .o_addr_src_EX  (addr_src_ex),
    .o_fence_EX     (fence_ex),
    .o_fence_stall  (fence_stall)
  );

  // word layout: jump,branch,rw,rs[1:0],mw,alu[4:0],asrc,adsrc,fence
  wire [13:0] ex_word = {jump_ex, branch_ex, reg_write_ex,
                         result_src_ex, mem_write_ex, alu_ctrl_ex,
                         alu_src_ex, addr_src_ex, fence_ex};

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [13:0] m_word;
  int         m_drain;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic rw, input logic [1:0] rs,
                                     input logic mw, input logic [4:0] alu,
                                     input logic f);
    return {1'b0, 1'b0, rw, rs, mw, alu, 1'b0, 1'b0, f};
  endfunction

  task automatic set_in(input logic [13:0] w);
    {jump, branch, reg_write, result_src, mem_write,
     alu_ctrl, alu_src, addr_src, fence} = w;
  endtask

  task automatic cyc(input string tag, input logic e, input logic fl,
                     input logic [13:0] w);
    @(negedge clk);
    en = e;
    flush = fl;
    set_in(w);
    @(posedge clk);
    if (m_drain > 0) begin
      m_word = '0;
      m_drain--;
    end else if (fl) begin
      m_word = '0;
    end else if (e) begin
      m_word = w;
      if (w[0]) m_drain = DC;
    end
    #1;
    chk({tag, "_word"}, 32'(ex_word), 32'(m_word));
    chk({tag, "_stall"}, 32'(fence_stall), 32'(m_drain > 0));
  endtask

  logic [13:0] base;
  logic [13:0] rw;

  initial begin
    m_word  = '0;
    m_drain = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    flush   = 1'b0;
    set_in(14'($urandom));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", 32'(ex_word), 32'd0);
    chk("rst_stall", 32'(fence_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    base = mk(1'b1, 2'b01, 1'b0, 5'h0A, 1'b0);
    cyc("load", 1'b1, 1'b0, base);
    chk("load_rs", 32'(result_src_ex), 32'h1);
    chk("load_alu", 32'(alu_ctrl_ex), 32'h0A);

    for (int i = 0; i < 3; i++) begin
      rw = 14'($urandom);
      cyc("hold", 1'b0, 1'b0, rw);
    end
    cyc("flush_noen", 1'b0, 1'b1, 14'($urandom));

    cyc("fence_in", 1'b1, 1'b0, mk(1'b1, 2'b10, 1'b0, 5'h03, 1'b1));
    chk("fence_ex", 32'(fence_ex), 32'd1);
    for (int i = 0; i < 4; i++)
      cyc("drain_mw", 1'b1, 1'b0, mk(1'b1, 2'b00, 1'b1, 5'h11, 1'b0));

    cyc("flush_fence", 1'b1, 1'b1, mk(1'b1, 2'b00, 1'b0, 5'h01, 1'b1));
    cyc("post_ff", 1'b1, 1'b0, mk(1'b0, 2'b11, 1'b0, 5'h07, 1'b0));

    cyc("held_f0", 1'b0, 1'b0, mk(1'b0, 2'b00, 1'b0, 5'h02, 1'b1));
    cyc("held_f1", 1'b0, 1'b0, mk(1'b0, 2'b00, 1'b0, 5'h02, 1'b1));
    cyc("held_go", 1'b1, 1'b0, mk(1'b0, 2'b00, 1'b0, 5'h02, 1'b1));
    for (int i = 0; i < 4; i++)
      cyc("held_dr", 1'b1, 1'b1, mk(1'b0, 2'b00, 1'b0, 5'h04, 1'b0));

    cyc("ar_in", 1'b1, 1'b0, mk(1'b1, 2'b01, 1'b1, 5'h1F, 1'b1));
    cyc("ar_d1", 1'b1, 1'b0, 14'h0);
    #2;
    rst_n   = 1'b0;
    m_word  = '0;
    m_drain = 0;
    #1;
    chk("arst_stall", 32'(fence_stall), 32'd0);
    chk("arst_word", 32'(ex_word), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("ar_resume", 1'b1, 1'b0, mk(1'b1, 2'b10, 1'b1, 5'h15, 1'b0));

    for (int i = 0; i < 400; i++) begin
      rw = 14'($urandom);
      rw[0] = ($urandom_range(0, 7) == 0);
      cyc("rnd", ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
